// File: rtl/local_memory_pkg.sv
// rtl/local_memory_pkg.sv - shared types, constants and helpers for the local memory arbiter
package local_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESPOND
    } state_t;

    localparam logic [7:0] BYTE_FILL = 8'hFF;

    // Unselected byte lanes read back as BYTE_FILL so requesters never see stale bytes
    function automatic logic [31:0] merge_bytes(input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] merged;
        merged = '0;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = mask[b] ? data[b*8 +: 8] : BYTE_FILL;
        end
        return merged;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin grant search starting after lastGrant
module round_robin_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     lastGrant,
    output logic                 grantValid,
    output logic [IDX_W-1:0]     grantIndex
);

    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the port right after lastGrant wins last-assignment
    always_comb begin
        grantValid = 1'b0;
        grantIndex = '0;
        idx        = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = IDX_W'((int'(lastGrant) + k) % NUM_PORTS);
            if (req[idx]) begin
                grantValid = 1'b1;
                grantIndex = idx;
            end
        end
    end

endmodule

// File: rtl/local_memory_arbiter_rw.sv
// rtl/local_memory_arbiter_rw.sv - round-robin arbiter of NUM_PORTS requesters onto one SRAM RW port
module local_memory_arbiter_rw
    import local_memory_pkg::*;
#(
    parameter int NUM_PORTS         = 2,
    parameter int ADDRESS_SIZE      = 24,
    parameter int SRAM_ADDRESS_SIZE = 9
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            portEnable,
    input  logic [NUM_PORTS-1:0]            portWriteEnable,
    input  logic [NUM_PORTS*ADDRESS_SIZE-1:0] portAddress,
    input  logic [NUM_PORTS*4-1:0]          portByteSelect,
    input  logic [NUM_PORTS*32-1:0]         portDataWrite,
    output logic [NUM_PORTS*32-1:0]         portDataRead,
    output logic [NUM_PORTS-1:0]            portBusy,
    output logic                            sram_select,
    output logic                            sram_writeEnable,
    output logic [SRAM_ADDRESS_SIZE-1:0]    sram_address,
    output logic [3:0]                      sram_writeMask,
    output logic [31:0]                     sram_dataWrite,
    input  logic [31:0]                     sram_dataRead
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [ADDRESS_SIZE-1:0] addr  [NUM_PORTS];
    logic [3:0]              bsel  [NUM_PORTS];
    logic [31:0]             wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]    in_range;
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    done;

    state_t           state;
    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] grant;
    logic [31:0]      read_buffer;
    logic             grantValid;
    logic [IDX_W-1:0] grantIndex;
    logic             misaligned;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign addr[i]  = portAddress[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign bsel[i]  = portByteSelect[i*4 +: 4];
        assign wdata[i] = portDataWrite[i*32 +: 32];

        // Addresses above this tile belong to another tile's decoder
        if (ADDRESS_SIZE > SRAM_ADDRESS_SIZE + 2) begin : g_range
            assign in_range[i] = (addr[i][ADDRESS_SIZE-1:SRAM_ADDRESS_SIZE+2] == '0);
        end else begin : g_full
            assign in_range[i] = 1'b1;
        end

        assign req[i]               = portEnable[i] & in_range[i];
        assign portBusy[i]          = req[i] & ~done[i];
        assign portDataRead[i*32 +: 32] = done[i] ? read_buffer : {4{BYTE_FILL}};
    end

    round_robin_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_arbiter (
        .req       (req),
        .lastGrant (lastGrant),
        .grantValid(grantValid),
        .grantIndex(grantIndex)
    );

    assign misaligned = (addr[grantIndex][1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lastGrant        <= IDX_W'(NUM_PORTS - 1);
            grant            <= '0;
            done             <= '0;
            read_buffer      <= '1;
            sram_select      <= 1'b0;
            sram_writeEnable <= 1'b0;
            sram_address     <= '0;
            sram_writeMask   <= '0;
            sram_dataWrite   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        lastGrant   <= grantIndex;
                        grant       <= grantIndex;
                        read_buffer <= '1;
                        if (misaligned) begin
                            done  <= NUM_PORTS'(1) << grantIndex;
                            state <= RESPOND;
                        end else begin
                            sram_select      <= 1'b1;
                            sram_writeEnable <= portWriteEnable[grantIndex];
                            sram_address     <= addr[grantIndex][SRAM_ADDRESS_SIZE+1:2];
                            sram_writeMask   <= bsel[grantIndex];
                            sram_dataWrite   <= wdata[grantIndex];
                            state            <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    sram_select      <= 1'b0;
                    sram_writeEnable <= 1'b0;
                    if (sram_writeEnable) begin
                        done  <= NUM_PORTS'(1) << grant;
                        state <= RESPOND;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // writeMask still holds the requester's byte select for this read
                    read_buffer <= merge_bytes(sram_dataRead, sram_writeMask);
                    done        <= NUM_PORTS'(1) << grant;
                    state       <= RESPOND;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_local_memory_arbiter_rw.sv
// tb/tb_local_memory_arbiter_rw.sv - directed self-checking bench for local_memory_arbiter_rw
module tb_local_memory_arbiter_rw;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int SW = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   en, wen;
    logic [NP*AW-1:0] addr_bus;
    logic [NP*4-1:0] bs_bus;
    logic [NP*32-1:0] wd_bus;
    logic [NP*32-1:0] rd_bus;
    logic [NP-1:0]   busy;
    logic            sram_select, sram_writeEnable;
    logic [SW-1:0]   sram_address;
    logic [3:0]      sram_writeMask;
    logic [31:0]     sram_dataWrite;
    logic [31:0]     sram_dataRead;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    local_memory_arbiter_rw #(
        .NUM_PORTS(NP), .ADDRESS_SIZE(AW), .SRAM_ADDRESS_SIZE(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .portEnable(en), .portWriteEnable(wen), .portAddress(addr_bus),
        .portByteSelect(bs_bus), .portDataWrite(wd_bus), .portDataRead(rd_bus),
        .portBusy(busy),
        .sram_select(sram_select), .sram_writeEnable(sram_writeEnable),
        .sram_address(sram_address), .sram_writeMask(sram_writeMask),
        .sram_dataWrite(sram_dataWrite), .sram_dataRead(sram_dataRead)
    );

    // SRAM model: word k preloads to A000_0000+k; read data appears the cycle after select
    logic [31:0] mem [512];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 512; k++) mem[k] <= 32'hA000_0000 + k;
            mem_ready <= 1'b1;
        end else if (sram_select) begin
            if (sram_writeEnable) begin
                for (int b = 0; b < 4; b++)
                    if (sram_writeMask[b]) mem[sram_address][b*8 +: 8] <= sram_dataWrite[b*8 +: 8];
            end else begin
                sram_dataRead <= mem[sram_address];
            end
        end
    end

    int   sel_count = 0;
    int   overlaps  = 0;
    logic prev_sel  = 1'b0;
    always @(negedge clk) begin
        if (sram_select) sel_count++;
        if (sram_select && prev_sel) overlaps++;
        prev_sel = sram_select;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [SW-1:0] snap_addr;
    logic [3:0]    snap_mask;
    logic          snap_sel, snap_we;
    logic [31:0]   snap_data;
    logic [31:0]   after_rd;

    task automatic access(input int p, input logic w, input logic [AW-1:0] a, input logic [3:0] bs,
                          input logic [31:0] d, output int lat, output logic [31:0] rd);
        en[p] = 1'b1; wen[p] = w;
        addr_bus[p*AW +: AW] = a; bs_bus[p*4 +: 4] = bs; wd_bus[p*32 +: 32] = d;
        lat = -1; rd = 32'h0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin
                snap_sel = sram_select; snap_we = sram_writeEnable; snap_addr = sram_address;
                snap_mask = sram_writeMask; snap_data = sram_dataWrite;
            end
            if (!busy[p]) begin
                lat = c; rd = rd_bus[p*32 +: 32];
                break;
            end
            @(negedge clk); #1;
        end
        en[p] = 1'b0;
        @(negedge clk); #1;
        after_rd = rd_bus[p*32 +: 32];
    endtask

    task automatic wait_done(input int p, output int lat, output logic [31:0] rd);
        lat = -1; rd = 32'h0;
        for (int c = 0; c < 12; c++) begin
            if (!busy[p]) begin
                lat = c; rd = rd_bus[p*32 +: 32];
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          lat, s0, bad_rd, bad_sel;
    logic [31:0] rd;
    int          ev_port[$];
    int          ev_cyc[$];
    logic [31:0] ev_data[$];

    initial begin
        rst_n = 1'b0;
        en = '0; wen = '0; addr_bus = '0; bs_bus = '1; wd_bus = '0;
        en[0] = 1'b1; en[3] = 1'b1;
        addr_bus[3*AW +: AW] = 24'h00000C;
        repeat (3) @(negedge clk);
        #1;
        check("rst_select", sram_select, 1'b0);
        check("rst_we", sram_writeEnable, 1'b0);
        check("rst_addr", sram_address, 0);
        check("rst_mask", sram_writeMask, 0);
        check("rst_wdata", sram_dataWrite, 0);
        check("rst_rdata", rd_bus, {NP{32'hFFFFFFFF}});
        check("rst_busy0", busy[0], 1'b1);

        rst_n = 1'b1;
        wait_done(0, lat, rd);
        check("first_grant_lat", lat, 3);
        check("first_grant_other_busy", busy[3], 1'b1);
        check("first_grant_data", rd, 32'hA0000000);
        en[0] = 1'b0;
        @(negedge clk); #1;
        wait_done(3, lat, rd);
        check("second_grant_lat", lat, 3);
        check("second_grant_data", rd, 32'hA0000003);
        en[3] = 1'b0;
        @(negedge clk); #1;

        access(1, 1'b1, 24'h000010, 4'hF, 32'hDEADBEEF, lat, rd);
        check("wr_lat", lat, 2);
        check("wr_sel", snap_sel, 1'b1);
        check("wr_we", snap_we, 1'b1);
        check("wr_addr", snap_addr, 4);
        check("wr_mask", snap_mask, 4'hF);
        check("wr_data", snap_data, 32'hDEADBEEF);

        access(1, 1'b0, 24'h000010, 4'h3, 32'h0, lat, rd);
        check("rd_lat", lat, 3);
        check("rd_data", rd, 32'hFFFFBEEF);
        check("rd_data_after", after_rd, 32'hFFFFFFFF);

        s0 = sel_count;
        access(2, 1'b1, 24'h000011, 4'hF, 32'h12345678, lat, rd);
        check("mis_wr_lat", lat, 1);
        check("mis_wr_nosel", sel_count, s0);
        access(2, 1'b0, 24'h000013, 4'hF, 32'h0, lat, rd);
        check("mis_rd_lat", lat, 1);
        check("mis_rd_data", rd, 32'hFFFFFFFF);
        access(1, 1'b0, 24'h000010, 4'hF, 32'h0, lat, rd);
        check("mis_mem_unchanged", rd, 32'hDEADBEEF);

        s0 = sel_count;
        en = 4'b0011; wen = '0;
        addr_bus[0 +: AW] = 24'h100000; addr_bus[AW +: AW] = 24'h000010;
        #1;
        check("oor_busy", busy[0], 1'b0);
        check("oor_data", rd_bus[31:0], 32'hFFFFFFFF);
        wait_done(1, lat, rd);
        check("oor_peer_lat", lat, 3);
        check("oor_peer_data", rd, 32'hDEADBEEF);
        check("oor_data_at_done", rd_bus[31:0], 32'hFFFFFFFF);
        en = '0;
        @(negedge clk); #1;
        check("oor_one_access", sel_count, s0 + 1);

        en[2] = 1'b1; wen[2] = 1'b0; addr_bus[2*AW +: AW] = 24'h000020;
        @(negedge clk); #1;
        check("mid_issue_sel", sram_select, 1'b1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", sram_select, 1'b0);
        check("mid_rst_data", rd_bus[2*32 +: 32], 32'hFFFFFFFF);
        en[2] = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        bad_rd = 0; bad_sel = 0;
        for (int c = 0; c < 5; c++) begin
            if (rd_bus !== {NP{32'hFFFFFFFF}}) bad_rd++;
            if (sram_select !== 1'b0) bad_sel++;
            @(negedge clk); #1;
        end
        check("mid_rst_no_done", bad_rd, 0);
        check("mid_rst_no_sel", bad_sel, 0);

        en = '1; wen = '0; bs_bus = '1;
        for (int p = 0; p < NP; p++) addr_bus[p*AW +: AW] = AW'(32'h20 + 4*p);
        #1;
        for (int c = 0; c < 20; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!busy[p]) begin
                    ev_port.push_back(p);
                    ev_cyc.push_back(c);
                    ev_data.push_back(rd_bus[p*32 +: 32]);
                end
            end
            @(negedge clk); #1;
        end
        en = '0;
        check("rr_events", ev_port.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_port%0d", k), (k < ev_port.size()) ? ev_port[k] : -1, k % NP);
            check($sformatf("rr_cycle%0d", k), (k < ev_cyc.size()) ? ev_cyc[k] : -1, 3 + 4*k);
            check($sformatf("rr_data%0d", k), (k < ev_data.size()) ? ev_data[k] : 32'h0,
                  32'hA0000008 + (k % NP));
        end
        @(negedge clk); #1;
        check("no_overlap", overlaps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/local_memory_arbiter_rw.md
Name: local_memory_arbiter_rw

Overview:
- Parametrised successor to the two-port single-RW-port local memory interface.
- Arbitrates NUM_PORTS bus requesters onto one SRAM read/write port using round-robin priority.
- SRAM command outputs are registered; reads take an explicit capture stage; results return through a per-port busy/done handshake.
- Sits between core/DMA/Wishbone-side requesters and one OpenRAM-style RW macro in each local memory tile.

Parameters:
- NUM_PORTS, 2: number of requester ports, 2..8.
- ADDRESS_SIZE, 24: requester byte-address width.
- SRAM_ADDRESS_SIZE, 9: SRAM word-address width. Must satisfy ADDRESS_SIZE >= SRAM_ADDRESS_SIZE+2.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- portEnable  in  NUM_PORTS  per-port request.
- portWriteEnable  in  NUM_PORTS  per-port write (1) / read (0).
- portAddress  in  NUM_PORTS*ADDRESS_SIZE  packed byte addresses; port i at [i*ADDRESS_SIZE +: ADDRESS_SIZE].
- portByteSelect  in  NUM_PORTS*4  packed byte lanes.
- portDataWrite  in  NUM_PORTS*32  packed write data.
- portDataRead  out  NUM_PORTS*32  packed read data.
- portBusy  out  NUM_PORTS  stall to requester.
- sram_select  out  1  registered chip select.
- sram_writeEnable  out  1  registered write enable.
- sram_address  out  SRAM_ADDRESS_SIZE  registered word address.
- sram_writeMask  out  4  registered byte mask.
- sram_dataWrite  out  32  registered write data.
- sram_dataRead  in  32  SRAM read data, valid the cycle after the edge that sampled select.

Behaviour:
- Reset is asynchronous and active-low on rst_n. On reset:
  - state=IDLE; all sram_* outputs = 0; done=0; every portDataRead word = 32'hFFFFFFFF.
  - Round-robin pointer lastGrant = NUM_PORTS-1, so port 0 wins first.
  - Reset mid-access aborts the access: no response, and sram_select drops immediately.
- inRange[i] = (portAddress[i][ADDRESS_SIZE-1:SRAM_ADDRESS_SIZE+2] == 0).
- req[i] = portEnable[i] & inRange[i].
- Out-of-range requests are ignored: busy=0, data=all ones. Another tile decodes them.
- portBusy[i] = req[i] & ~done[i] (combinational).
- done[i] is a one-cycle registered pulse. portDataRead[i] equals the captured word only while done[i]=1, otherwise all ones.
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE:
  - If any req is set, grant g = first req[] found scanning from lastGrant+1 modulo NUM_PORTS; set lastGrant<=g.
  - If portAddress[g][1:0] != 0 (misaligned), go directly to RESPOND with no SRAM access; read data all ones, write dropped.
  - Otherwise register select=1, writeEnable, address[SRAM_ADDRESS_SIZE+1:2], writeMask=byteSelect, dataWrite; go to ISSUE.
- ISSUE: SRAM samples the command at the ending edge; clear sram_select and sram_writeEnable. Write goes to RESPOND; read goes to CAPTURE.
- CAPTURE: latch sram_dataRead into the read buffer, masking unselected bytes to 8'hFF; go to RESPOND.
- RESPOND: done[g]=1 for this cycle only, so portBusy[g]=0; go to IDLE. No arbitration occurs in RESPOND.
- Latency in cycles from request to busy low (cycle 0 = request):
  - Write: busy low in cycle 2.
  - Read: busy low in cycle 3.
  - Misaligned: busy low in cycle 1.
- Requester handshake: the requester must hold all inputs stable while busy=1. It must deassert enable or present a new request after the done cycle. Enable still high in IDLE is treated as a new request.
- Requests from ungranted ports are held off (busy=1) indefinitely with no loss.
- A grant is not revoked if the winning requester drops enable mid-access. The access completes; the done pulse is harmless.
- Simultaneous requests are served strictly round-robin, so no port starves. Worst-case wait is (NUM_PORTS-1)*4 cycles plus the requester's own access.

Decomposition:
- Package local_memory_pkg holds:
  - the state enum (IDLE/ISSUE/CAPTURE/RESPOND);
  - the BYTE_FILL=8'hFF constant;
  - a function for the byte-masking merge.
- Sub-module round_robin_arbiter (parameters NUM_PORTS): inputs req and lastGrant; outputs grantValid and grantIndex. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: hold rst_n=0 with port0 read enabled -> all sram_* = 0, portDataRead = all ones, portBusy[0]=1. Release -> first grant goes to port 0.
- Single write then read (port 1): write addr 0x10, byteSelect 4'hF, data 0xDEADBEEF -> sram_address=4, mask F, busy low in cycle 2. Read addr 0x10 with byteSelect 4'h3 -> portDataRead=0xFFFFBEEF in cycle 3 only.
- Contention: NUM_PORTS=4, all ports request reads simultaneously and hold -> grant order 0,1,2,3,0. Each done pulse is exactly one cycle. No two SRAM commands overlap.
- Misaligned address 0x11 write on port 2 -> sram_select never asserts, busy low in cycle 1, memory at word 4 unchanged.
- Out-of-range address 0x100000 on port 0 -> busy=0, data=all ones, no SRAM activity. A concurrent in-range port 1 request is granted in the same cycle.
- Mid-read async reset (assert rst_n=0 during CAPTURE) -> sram_select=0 immediately, no done pulse, state IDLE. Round robin restarts from port 0.
